// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// clock_pkg : shared limits, mode encoding and 7-segment table
// Rev 1.0
// ============================================================================
package clock_pkg;

    localparam int MAX_SEC  = 59;
    localparam int MAX_MIN  = 59;
    localparam int MAX_HOUR = 23;

    typedef enum logic [1:0] {
        CLOCK     = 2'd0,
        ALARM     = 2'd1,
        STOPWATCH = 2'd2,
        TIMER     = 2'd3
    } mode_e;

    // Segment codes {dp,g,f,e,d,c,b,a}, entry 0 at the right
    localparam logic [9:0][7:0] SEG_TABLE = {
        8'h6F, 8'h7F, 8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
    };

    function automatic logic [7:0] seg7(input logic [3:0] d);
        return (d < 4'd10) ? SEG_TABLE[d] : 8'h00;
    endfunction

    function automatic logic [3:0] bcd_tens(input logic [6:0] v);
        return 4'(v / 7'd10);
    endfunction

    function automatic logic [3:0] bcd_ones(input logic [6:0] v);
        return 4'(v % 7'd10);
    endfunction

endpackage
`default_nettype wire

// File: rtl/digital_clock_seg_scan.sv
`default_nettype none
// ============================================================================
// seg_scan : one-digit-per-cycle scan of an 8-digit 7-segment display
// Rev 1.0
// ============================================================================
module seg_scan (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] digits,
    output logic [7:0]  seg_data,
    output logic [7:0]  seg_sel
);
    import clock_pkg::*;

    logic [2:0] r_digit;
    logic [3:0] w_bcd;

    always_ff @(posedge clk) begin
        if (rst) r_digit <= 3'd0;
        else     r_digit <= r_digit + 3'd1;
    end

    // Digits 6 and 7 have no source and stay dark
    always_comb begin
        w_bcd = 4'd0;
        case (r_digit)
            3'd0:    w_bcd = digits[3:0];
            3'd1:    w_bcd = digits[7:4];
            3'd2:    w_bcd = digits[11:8];
            3'd3:    w_bcd = digits[15:12];
            3'd4:    w_bcd = digits[19:16];
            3'd5:    w_bcd = digits[23:20];
            default: w_bcd = 4'd0;
        endcase
        seg_sel  = ~(8'd1 << r_digit);
        seg_data = (r_digit < 3'd6) ? seg7(w_bcd) : 8'h00;
    end

endmodule
`default_nettype wire

// File: rtl/digital_clock.sv
`default_nettype none
// ============================================================================
// digital_clock : time of day, alarm, stopwatch, countdown timer, 7-seg scan
// Rev 1.0
// ============================================================================
module digital_clock #(
    parameter int TICKS_PER_SEC = 1000,
    parameter int CS_DIV        = 10
) (
    input  logic       clk_1k,
    input  logic       clr_sw_n,
    input  logic       alarm_sw,
    input  logic       stopwatch_sw,
    input  logic       timer_sw,
    input  logic [8:0] btn,
    output logic [7:0] seg_data,
    output logic [7:0] seg_sel,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data,
    output logic       piezo,
    output logic [7:0] led_1,
    output logic [3:0] led_r,
    output logic [3:0] led_g,
    output logic [3:0] led_b
);
    import clock_pkg::*;

    localparam int c_TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int c_CS_W   = (CS_DIV > 1) ? $clog2(CS_DIV) : 1;

    logic [8:0] r_btn, r_btn_prev, w_press;
    logic       w_unused_press;
    mode_e      w_mode;
    logic       w_clk_mode, w_sw_mode, w_tm_mode;

    logic [c_TICK_W-1:0] r_tick;
    logic                w_tick;
    logic [5:0]          r_sec, r_min;
    logic [4:0]          r_hour;
    logic [6:0]          w_sec_sum, w_min_sum;
    logic [5:0]          w_hour_sum;
    logic                w_sec_cy, w_min_cy;

    logic [4:0] r_al_hour;
    logic [5:0] r_al_min, r_ring_secs;
    logic       r_armed, r_ring, r_match_prev, w_match;

    logic [c_CS_W-1:0] r_sw_div;
    logic [6:0]        r_sw_cs;
    logic [5:0]        r_sw_sec, r_sw_min;
    logic              r_sw_run;

    logic [5:0] r_tm_min, r_tm_sec;
    logic       r_tm_run, r_tm_done, w_tm_zero;

    logic        r_piezo;
    logic [6:0]  w_v2, w_v1, w_v0;
    logic [23:0] w_digits;

    assign w_press        = r_btn & ~r_btn_prev;
    assign w_unused_press = ^w_press[7:6];
    assign w_mode = alarm_sw ? ALARM : stopwatch_sw ? STOPWATCH : timer_sw ? TIMER : CLOCK;
    assign w_clk_mode = (w_mode == CLOCK);
    assign w_sw_mode  = (w_mode == STOPWATCH);
    assign w_tm_mode  = (w_mode == TIMER);
    assign w_tick     = (r_tick == c_TICK_W'(TICKS_PER_SEC - 1));

    always_ff @(posedge clk_1k) begin
        if (clr_sw_n) begin
            r_btn      <= '0;
            r_btn_prev <= '0;
        end else begin
            r_btn      <= btn;
            r_btn_prev <= r_btn;
        end
    end

    // A tick and a seconds press may coincide, so carries are computed as sums
    always_comb begin
        w_sec_sum  = {1'b0, r_sec} + {6'd0, w_tick} + {6'd0, w_clk_mode & w_press[2]};
        w_sec_cy   = (w_sec_sum > 7'(MAX_SEC));
        w_min_sum  = {1'b0, r_min} + {6'd0, w_sec_cy} + {6'd0, w_clk_mode & w_press[1]};
        w_min_cy   = (w_min_sum > 7'(MAX_MIN));
        w_hour_sum = {1'b0, r_hour} + {5'd0, w_min_cy} + {5'd0, w_clk_mode & w_press[0]};
    end

    always_ff @(posedge clk_1k) begin
        if (clr_sw_n) begin
            r_tick <= '0;
            r_sec  <= '0;
            r_min  <= '0;
            r_hour <= '0;
        end else begin
            r_tick <= w_tick ? '0 : r_tick + c_TICK_W'(1);
            r_sec  <= w_sec_cy ? 6'(w_sec_sum - 7'(MAX_SEC + 1)) : w_sec_sum[5:0];
            r_min  <= w_min_cy ? 6'(w_min_sum - 7'(MAX_MIN + 1)) : w_min_sum[5:0];
            r_hour <= (w_hour_sum > 6'(MAX_HOUR)) ? 5'(w_hour_sum - 6'(MAX_HOUR + 1))
                                                 : w_hour_sum[4:0];
        end
    end

    assign w_match = r_armed && (r_hour == r_al_hour) && (r_min == r_al_min) && (r_sec == 6'd0);

    // Ringing starts only on the rising edge of a match so btn[8] silences it for good
    always_ff @(posedge clk_1k) begin
        if (clr_sw_n) begin
            r_al_hour    <= '0;
            r_al_min     <= '0;
            r_armed      <= 1'b0;
            r_ring       <= 1'b0;
            r_ring_secs  <= '0;
            r_match_prev <= 1'b0;
        end else begin
            r_match_prev <= w_match;
            if (w_mode == ALARM) begin
                if (w_press[0]) r_al_hour <= (r_al_hour == 5'(MAX_HOUR)) ? '0 : r_al_hour + 5'd1;
                if (w_press[1]) r_al_min  <= (r_al_min == 6'(MAX_MIN)) ? '0 : r_al_min + 6'd1;
                if (w_press[5]) r_armed   <= ~r_armed;
            end
            if (r_ring) begin
                if (w_press[8] || (w_tick && r_ring_secs == 6'd59)) begin
                    r_ring      <= 1'b0;
                    r_ring_secs <= '0;
                end else if (w_tick) begin
                    r_ring_secs <= r_ring_secs + 6'd1;
                end
            end else if (w_match && !r_match_prev) begin
                r_ring      <= 1'b1;
                r_ring_secs <= '0;
            end
        end
    end

    always_ff @(posedge clk_1k) begin
        if (clr_sw_n) begin
            r_sw_run <= 1'b0;
            r_sw_div <= '0;
            r_sw_cs  <= '0;
            r_sw_sec <= '0;
            r_sw_min <= '0;
        end else begin
            if (w_sw_mode && w_press[3]) r_sw_run <= ~r_sw_run;
            if (w_sw_mode && w_press[4] && !r_sw_run) begin
                r_sw_div <= '0;
                r_sw_cs  <= '0;
                r_sw_sec <= '0;
                r_sw_min <= '0;
            end else if (r_sw_run) begin
                if (r_sw_div == c_CS_W'(CS_DIV - 1)) begin
                    r_sw_div <= '0;
                    if (r_sw_cs == 7'd99) begin
                        r_sw_cs <= '0;
                        if (r_sw_sec == 6'(MAX_SEC)) begin
                            r_sw_sec <= '0;
                            r_sw_min <= (r_sw_min == 6'(MAX_MIN)) ? '0 : r_sw_min + 6'd1;
                        end else begin
                            r_sw_sec <= r_sw_sec + 6'd1;
                        end
                    end else begin
                        r_sw_cs <= r_sw_cs + 7'd1;
                    end
                end else begin
                    r_sw_div <= r_sw_div + c_CS_W'(1);
                end
            end
        end
    end

    assign w_tm_zero = (r_tm_min == 6'd0) && (r_tm_sec == 6'd0);

    always_ff @(posedge clk_1k) begin
        if (clr_sw_n) begin
            r_tm_min  <= '0;
            r_tm_sec  <= '0;
            r_tm_run  <= 1'b0;
            r_tm_done <= 1'b0;
        end else begin
            if (w_press[8]) r_tm_done <= 1'b0;
            if (w_tm_mode && !r_tm_run) begin
                if (w_press[1]) r_tm_min <= (r_tm_min == 6'(MAX_MIN)) ? '0 : r_tm_min + 6'd1;
                if (w_press[2]) r_tm_sec <= (r_tm_sec == 6'(MAX_SEC)) ? '0 : r_tm_sec + 6'd1;
            end
            if (w_tm_mode && w_press[3]) begin
                if (r_tm_run) begin
                    r_tm_run <= 1'b0;
                end else if (!w_tm_zero) begin
                    r_tm_run  <= 1'b1;
                    r_tm_done <= 1'b0;
                end
            end else if (r_tm_run && w_tick) begin
                if (r_tm_sec != 6'd0) begin
                    r_tm_sec <= r_tm_sec - 6'd1;
                end else begin
                    r_tm_sec <= 6'(MAX_SEC);
                    r_tm_min <= r_tm_min - 6'd1;
                end
                if (r_tm_min == 6'd0 && r_tm_sec == 6'd1) begin
                    r_tm_run  <= 1'b0;
                    r_tm_done <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_1k) begin
        if (clr_sw_n) r_piezo <= 1'b0;
        else          r_piezo <= (r_ring || r_tm_done) ? ~r_piezo : 1'b0;
    end

    always_comb begin
        w_v2 = {2'b00, r_hour};
        w_v1 = {1'b0, r_min};
        w_v0 = {1'b0, r_sec};
        case (w_mode)
            ALARM: begin
                w_v2 = {2'b00, r_al_hour};
                w_v1 = {1'b0, r_al_min};
                w_v0 = 7'd0;
            end
            STOPWATCH: begin
                w_v2 = {1'b0, r_sw_min};
                w_v1 = {1'b0, r_sw_sec};
                w_v0 = r_sw_cs;
            end
            TIMER: begin
                w_v2 = 7'd0;
                w_v1 = {1'b0, r_tm_min};
                w_v0 = {1'b0, r_tm_sec};
            end
            default: ;
        endcase
        w_digits = {bcd_ones(w_v0), bcd_tens(w_v0), bcd_ones(w_v1), bcd_tens(w_v1),
                    bcd_ones(w_v2), bcd_tens(w_v2)};
    end

    seg_scan u_seg_scan (
        .clk      (clk_1k),
        .rst      (clr_sw_n),
        .digits   (w_digits),
        .seg_data (seg_data),
        .seg_sel  (seg_sel)
    );

    assign lcd_rs   = 1'b0;
    assign lcd_rw   = 1'b0;
    assign lcd_e    = 1'b0;
    assign lcd_data = 8'h00;
    assign piezo    = r_piezo;
    assign led_1    = {2'b00, r_sec};
    assign led_r    = r_ring ? 4'hF : {3'b000, r_armed};
    assign led_g    = r_sw_run ? 4'hF : 4'h0;
    assign led_b    = r_tm_run ? 4'hF : (r_tm_done ? 4'h5 : 4'h0);

endmodule
`default_nettype wire

// File: tb/tb_digital_clock.sv
`default_nettype none
// ============================================================================
// tb_digital_clock : directed checks on a slow-tick and a fast-tick instance
// Rev 1.0
// ============================================================================
module tb_digital_clock;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr_sw_n = 1'b0, alarm_sw = 1'b0, stopwatch_sw = 1'b0, timer_sw = 1'b0;
    logic [8:0] btn = '0;

    logic [7:0] seg_data_s, seg_sel_s, lcd_data_s, led_1_s;
    logic       lcd_rs_s, lcd_rw_s, lcd_e_s, piezo_s;
    logic [3:0] led_r_s, led_g_s, led_b_s;
    logic [7:0] seg_data_f, seg_sel_f, lcd_data_f, led_1_f;
    logic       lcd_rs_f, lcd_rw_f, lcd_e_f, piezo_f;
    logic [3:0] led_r_f, led_g_f, led_b_f;

    int n_cmp = 0;
    int n_bad = 0;

    // Display images: byte i is digit i, digits 6-7 blank
    localparam logic [63:0] D_000000 = 64'h0000_3F3F_3F3F_3F3F;
    localparam logic [63:0] D_235958 = 64'h0000_7F6D_6F6D_4F5B;
    localparam logic [63:0] D_235959 = 64'h0000_6F6D_6F6D_4F5B;
    localparam logic [63:0] D_000100 = 64'h0000_3F3F_063F_3F3F;
    localparam logic [63:0] D_000002 = 64'h0000_5B3F_3F3F_3F3F;

    digital_clock #(.TICKS_PER_SEC(1_000_000), .CS_DIV(10)) u_slow (
        .clk_1k(clk), .clr_sw_n(clr_sw_n), .alarm_sw(alarm_sw), .stopwatch_sw(stopwatch_sw),
        .timer_sw(timer_sw), .btn(btn), .seg_data(seg_data_s), .seg_sel(seg_sel_s),
        .lcd_rs(lcd_rs_s), .lcd_rw(lcd_rw_s), .lcd_e(lcd_e_s), .lcd_data(lcd_data_s),
        .piezo(piezo_s), .led_1(led_1_s), .led_r(led_r_s), .led_g(led_g_s), .led_b(led_b_s)
    );

    digital_clock #(.TICKS_PER_SEC(10), .CS_DIV(10)) u_fast (
        .clk_1k(clk), .clr_sw_n(clr_sw_n), .alarm_sw(alarm_sw), .stopwatch_sw(stopwatch_sw),
        .timer_sw(timer_sw), .btn(btn), .seg_data(seg_data_f), .seg_sel(seg_sel_f),
        .lcd_rs(lcd_rs_f), .lcd_rw(lcd_rw_f), .lcd_e(lcd_e_f), .lcd_data(lcd_data_f),
        .piezo(piezo_f), .led_1(led_1_f), .led_r(led_r_f), .led_g(led_g_f), .led_b(led_b_f)
    );

    task automatic do_reset();
        @(negedge clk) clr_sw_n = 1'b1;
        @(negedge clk) clr_sw_n = 1'b0;
    endtask

    task automatic press(input int b, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk) btn[b] = 1'b1;
            @(negedge clk) btn[b] = 1'b0;
        end
    endtask

    task automatic capture(input bit fast, output logic [63:0] disp);
        logic [7:0] sel, dat;
        disp = 'x;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            sel = fast ? seg_sel_f : seg_sel_s;
            dat = fast ? seg_data_f : seg_data_s;
            for (int i = 0; i < 8; i++)
                if (sel == ~(8'd1 << i)) disp[i*8 +: 8] = dat;
        end
    endtask

    task automatic test_reset();
        logic [63:0] d;
        do_reset();
        n_cmp++; if (seg_sel_f !== 8'hFE) begin n_bad++; $display("FAIL reset_seg_sel got=%h exp=%h", seg_sel_f, 8'hFE); end
        n_cmp++; if (seg_data_f !== 8'h3F) begin n_bad++; $display("FAIL reset_seg_data got=%h exp=%h", seg_data_f, 8'h3F); end
        n_cmp++; if ({piezo_f, led_1_f, led_r_f, led_g_f, led_b_f} !== 21'd0) begin
            n_bad++; $display("FAIL reset_leds got=%b%h%h%h%h exp=0", piezo_f, led_1_f, led_r_f, led_g_f, led_b_f); end
        n_cmp++; if ({lcd_rs_s, lcd_rw_s, lcd_e_s, lcd_data_s} !== 11'd0) begin
            n_bad++; $display("FAIL reset_lcd got=%b%b%b%h exp=0", lcd_rs_s, lcd_rw_s, lcd_e_s, lcd_data_s); end
        capture(1'b0, d);
        n_cmp++; if (d !== D_000000) begin n_bad++; $display("FAIL reset_display got=%h exp=%h", d, D_000000); end
    endtask

    task automatic test_button_set();
        logic [63:0] d;
        do_reset();
        press(0, 23);
        press(1, 59);
        press(2, 58);
        capture(1'b0, d);
        n_cmp++; if (d !== D_235958) begin n_bad++; $display("FAIL set_display got=%h exp=%h", d, D_235958); end
        n_cmp++; if (led_1_s !== 8'd58) begin n_bad++; $display("FAIL set_led1 got=%0d exp=58", led_1_s); end
    endtask

    task automatic test_rollover();
        logic [63:0] d;
        press(2, 1);
        capture(1'b0, d);
        n_cmp++; if (d !== D_235959) begin n_bad++; $display("FAIL roll_display_59 got=%h exp=%h", d, D_235959); end
        n_cmp++; if (led_1_s !== 8'd59) begin n_bad++; $display("FAIL roll_led1_59 got=%0d exp=59", led_1_s); end
        press(2, 1);
        capture(1'b0, d);
        n_cmp++; if (d !== D_000000) begin n_bad++; $display("FAIL roll_display_wrap got=%h exp=%h", d, D_000000); end
        n_cmp++; if (led_1_s !== 8'd0) begin n_bad++; $display("FAIL roll_led1_wrap got=%0d exp=0", led_1_s); end
    endtask

    task automatic test_tick();
        logic [63:0] d;
        do_reset();
        repeat (599) @(negedge clk);
        n_cmp++; if (led_1_f !== 8'd59) begin n_bad++; $display("FAIL tick_led1_59 got=%0d exp=59", led_1_f); end
        repeat (2) @(negedge clk);
        capture(1'b1, d);
        n_cmp++; if (d !== D_000100) begin n_bad++; $display("FAIL tick_display got=%h exp=%h", d, D_000100); end
        n_cmp++; if (led_1_f !== 8'd0) begin n_bad++; $display("FAIL tick_led1_0 got=%0d exp=0", led_1_f); end
    endtask

    task automatic test_alarm();
        logic [63:0] d;
        bit found;
        do_reset();
        alarm_sw = 1'b1;
        press(1, 1);
        press(5, 1);
        @(negedge clk);
        n_cmp++; if (led_r_f !== 4'h1) begin n_bad++; $display("FAIL alarm_armed_led got=%h exp=1", led_r_f); end
        capture(1'b1, d);
        n_cmp++; if (d !== D_000100) begin n_bad++; $display("FAIL alarm_display got=%h exp=%h", d, D_000100); end
        alarm_sw = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 700 && !found; k++) begin
            @(negedge clk);
            if (piezo_f === 1'b1) found = 1'b1;
        end
        n_cmp++; if (!found) begin n_bad++; $display("FAIL alarm_ring_timeout got=no_piezo exp=piezo_high"); end
        n_cmp++; if (led_r_f !== 4'hF) begin n_bad++; $display("FAIL alarm_ring_led got=%h exp=F", led_r_f); end
        n_cmp++; if (led_1_f !== 8'd0) begin n_bad++; $display("FAIL alarm_ring_sec got=%0d exp=0", led_1_f); end
        @(negedge clk);
        n_cmp++; if (piezo_f !== 1'b0) begin n_bad++; $display("FAIL alarm_piezo_toggle got=%b exp=0", piezo_f); end
        press(8, 1);
        repeat (2) @(negedge clk);
        n_cmp++; if (led_r_f !== 4'h1) begin n_bad++; $display("FAIL alarm_stop_led got=%h exp=1", led_r_f); end
        n_cmp++; if (piezo_f !== 1'b0) begin n_bad++; $display("FAIL alarm_stop_piezo got=%b exp=0", piezo_f); end
    endtask

    task automatic test_stopwatch();
        logic [63:0] d;
        do_reset();
        stopwatch_sw = 1'b1;
        press(3, 1);
        @(negedge clk);
        n_cmp++; if (led_g_f !== 4'hF) begin n_bad++; $display("FAIL sw_run_led got=%h exp=F", led_g_f); end
        repeat (997) @(negedge clk);
        press(3, 1);
        @(negedge clk);
        n_cmp++; if (led_g_f !== 4'h0) begin n_bad++; $display("FAIL sw_stop_led got=%h exp=0", led_g_f); end
        capture(1'b1, d);
        n_cmp++; if (d !== D_000100) begin n_bad++; $display("FAIL sw_1s_display got=%h exp=%h", d, D_000100); end
        press(4, 1);
        capture(1'b1, d);
        n_cmp++; if (d !== D_000000) begin n_bad++; $display("FAIL sw_clear_display got=%h exp=%h", d, D_000000); end
        stopwatch_sw = 1'b0;
    endtask

    task automatic test_timer_reset();
        logic [63:0] d;
        logic        p0;
        do_reset();
        timer_sw = 1'b1;
        press(2, 2);
        capture(1'b1, d);
        n_cmp++; if (d !== D_000002) begin n_bad++; $display("FAIL tm_set_display got=%h exp=%h", d, D_000002); end
        press(3, 1);
        @(negedge clk);
        n_cmp++; if (led_b_f !== 4'hF) begin n_bad++; $display("FAIL tm_run_led got=%h exp=F", led_b_f); end
        repeat (22) @(negedge clk);
        n_cmp++; if (led_b_f !== 4'h5) begin n_bad++; $display("FAIL tm_done_led got=%h exp=5", led_b_f); end
        p0 = piezo_f;
        @(negedge clk);
        n_cmp++; if (piezo_f !== ~p0) begin n_bad++; $display("FAIL tm_piezo_toggle got=%b exp=%b", piezo_f, ~p0); end
        capture(1'b1, d);
        n_cmp++; if (d !== D_000000) begin n_bad++; $display("FAIL tm_zero_display got=%h exp=%h", d, D_000000); end
        do_reset();
        n_cmp++; if ({seg_sel_f, seg_data_f} !== 16'hFE3F) begin
            n_bad++; $display("FAIL tm_reset_seg got=%h%h exp=FE3F", seg_sel_f, seg_data_f); end
        n_cmp++; if ({piezo_f, led_1_f, led_r_f, led_g_f, led_b_f} !== 21'd0) begin
            n_bad++; $display("FAIL tm_reset_leds got=%b%h%h%h%h exp=0", piezo_f, led_1_f, led_r_f, led_g_f, led_b_f); end
        @(negedge clk);
        n_cmp++; if (piezo_f !== 1'b0) begin n_bad++; $display("FAIL tm_reset_piezo_hold got=%b exp=0", piezo_f); end
        timer_sw = 1'b0;
    endtask

    initial begin
        test_reset();
        test_button_set();
        test_rollover();
        test_tick();
        test_alarm();
        test_stopwatch();
        test_timer_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/digital_clock.md
Name: digital_clock

Overview:
- Top-level wall clock for the 1 kHz board clock.
- Keeps time of day (HH:MM:SS) and set from buttons.
- Provides an alarm, a stopwatch and a countdown timer.
- Drives a multiplexed 8-digit 7-segment display, a piezo and status LEDs.
- LCD port is present but held idle in this block.

Parameters:
- TICKS_PER_SEC, 1000: clk_1k cycles per 1-second tick. Bench may override it.
- CS_DIV, 10: clk_1k cycles per stopwatch centisecond.

Ports:
- clk_1k  in  1  system clock. The design has one clock; all logic is on the rising edge.
- clr_sw_n  in  1  reset. Synchronous and active-high. The legacy port name is kept; the _n suffix does not mean active-low.
- alarm_sw  in  1  alarm-set/view mode.
- stopwatch_sw  in  1  stopwatch mode.
- timer_sw  in  1  timer mode.
- btn  in  9  push buttons, active-high, may be asserted for a single clock cycle.
- seg_data  out  8  segments {dp,g,f,e,d,c,b,a}, active-high.
- seg_sel  out  8  digit select, one-hot, active-low.
- lcd_rs, lcd_rw, lcd_e  out  1 each  LCD control, constant 0.
- lcd_data  out  8  LCD data, constant 0.
- piezo  out  1  buzzer drive.
- led_1  out  8  binary seconds: {2'b00, sec}.
- led_r, led_g, led_b  out  4 each  status LEDs.

Behaviour:
- Reset (clr_sw_n=1 at a clock edge) clears every register:
  - time, alarm, timer values and all counters to 0; alarm disarmed.
  - Outputs after reset: seg_sel=8'hFE, seg_data shows digit 0 ('0' = 8'h3F), piezo=0, all LEDs 0.
- Buttons:
  - Each btn bit is registered once; an action fires on the rising edge (prev=0, cur=1). One action per press.
  - Actions take effect in the cycle after the registered edge.
- Mode priority: alarm_sw > stopwatch_sw > timer_sw > clock mode.
- Time of day always runs in every mode.
  - A tick counter 0..TICKS_PER_SEC-1 advances sec.
  - Wraps: sec 59->0 carries to min; min 59->0 carries to hour; hour 23->0.
- Clock mode (no switch set):
  - btn[0]: hour+1.
  - btn[1]: min+1, with carry into hour.
  - btn[2]: sec+1, with carry to min and hour.
  - Button carries wrap exactly like tick carries: 23:59:59 + btn[2] gives 00:00:00.
  - If a tick and a btn[2] press land in the same cycle, sec advances by 2 with correct carry.
- Alarm mode:
  - btn[0]: alarm hour+1, mod 24. btn[1]: alarm min+1, mod 60, no carry.
  - btn[5]: toggle armed.
  - Display shows alarm HH:MM with the seconds digits at 00.
- Alarm ringing:
  - Starts when armed and time hh:mm equals the alarm with sec=0.
  - Stops on a btn[8] press or after 60 s.
- Stopwatch mode:
  - btn[3]: start/stop. btn[4]: clear to 0, allowed only while stopped.
  - Counts MM:SS:CC with a centisecond every CS_DIV cycles; wraps at 59:59:99 to 0.
  - Keeps running when the mode switch is left.
- Timer mode:
  - btn[1]: timer min+1, mod 60. btn[2]: timer sec+1, mod 60. Editable only while stopped.
  - btn[3]: start/stop; it does not start when the value is 00:00.
  - While running it counts down once per second tick.
  - On reaching 00:00 it stops and sets timer_done.
  - btn[8], or a new start, clears timer_done.
- Display:
  - Scan one digit per clk_1k cycle in the order digit0..digit7, then repeat.
  - Digits 0-5 show the selected mode's value: HH MM SS, stopwatch MM SS CC, or timer 00 MM SS.
  - Digits 6-7 are blank (8'h00). dp is off everywhere.
  - Standard hex 0-9 decoding.
- piezo:
  - Toggles every clock cycle while ringing or timer_done; 0 otherwise.
- Status LEDs:
  - led_r = 4'hF while ringing, else {3'b0, armed}.
  - led_g = 4'hF while the stopwatch runs.
  - led_b = 4'hF while the timer runs; 4'h5 while timer_done.
- Reset mid-operation aborts everything immediately, including ringing and running counters.

Decomposition:
- Shared package clock_pkg holds:
  - constants MAX_SEC=59, MAX_MIN=59, MAX_HOUR=23.
  - the 7-seg code table.
  - a mode enum {CLOCK, ALARM, STOPWATCH, TIMER}.
- One natural sub-module: seg_scan, covering the digit counter, BCD-to-segment decode and seg_sel generation.
- Time, alarm, stopwatch and timer logic stay in the top-level module.

Test Plan:
- Button setting (TICKS_PER_SEC=1_000_000): reset; 23x btn[0], 59x btn[1], 58x btn[2] -> display 23:59:58, led_1=58.
- Rollover by button: from 23:59:58, btn[2] -> 23:59:59; btn[2] again -> 00:00:00, led_1=0.
- Natural tick (TICKS_PER_SEC=10): after reset, wait 600 cycles -> 00:01:00.
- Alarm (TICKS_PER_SEC=10): set alarm 00:01, arm with btn[5] (led_r=1), return to clock mode. At 00:01:00 piezo toggles and led_r=F; btn[8] stops it.
- Stopwatch: start, run 1000 cycles, stop -> 00:01:00 (1 s); clear with btn[4] -> 00:00:00.
- Timer/reset: set 00:00:02, start with TICKS_PER_SEC=10. After 20 cycles it is 00:00, timer_done, piezo toggling, led_b=5. Then clr_sw_n=1 for one cycle -> all outputs at reset values.
